// File: rtl/lif_neuron_layer2.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_layer2
// Description : Single leaky integrate-and-fire neuron for layer 2. It
//               integrates a signed 8-bit current into a saturating signed
//               membrane potential and fires when the potential reaches
//               THRESHOLD. After each spike it ignores input for
//               REFRAC_CYCLES clocks. It keeps a saturating 8-bit spike count.
//               Optional feature macro: LIF_NEURON_LEAK_EN. When defined, the
//               membrane leaks by (membrane >>> LEAK_SHIFT) on each accepted
//               input.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_layer2 #(
  parameter int MEM_WIDTH     = 10,
  parameter int THRESHOLD     = 64,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [7:0]                  current,
  output logic                        in_ready,
  output logic                        spike,
  output logic signed [MEM_WIDTH-1:0] membrane,
  output logic [7:0]                  spike_count
);

  // Two guard bits are enough for mem - leak + current before saturating.
  localparam int W2 = MEM_WIDTH + 2;
  localparam int CW = $clog2(REFRAC_CYCLES + 2);

  localparam logic [CW-1:0]        REFRAC_LOAD = CW'(REFRAC_CYCLES);
  localparam logic [CW-1:0]        CNT_ONE     = CW'(1);
  localparam bit                   HAS_REFRAC  = (REFRAC_CYCLES != 0);
  localparam logic signed [W2-1:0] SAT_MAX     = {3'b000, {(MEM_WIDTH-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN     = {3'b111, {(MEM_WIDTH-1){1'b0}}};
  localparam logic signed [31:0]   THR         = THRESHOLD;

`ifdef LIF_NEURON_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    INTEGRATE = 1'b0,
    REFRAC    = 1'b1
  } state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cnt;
  logic signed [MEM_WIDTH-1:0]   r_mem;
  logic                          r_spike;
  logic [7:0]                    r_count;

  logic signed [MEM_WIDTH-1:0]   w_leak;
  logic signed [W2-1:0]          w_mem_x;
  logic signed [W2-1:0]          w_leak_x;
  logic signed [W2-1:0]          w_cur_x;
  logic signed [W2-1:0]          w_sum;
  logic signed [MEM_WIDTH-1:0]   w_vnext;
  logic signed [31:0]            w_vcmp;
  logic                          w_fire;

  // The leak is a constant zero when the feature is compiled out.
  assign w_leak   = LEAK_EN ? (r_mem >>> LEAK_SHIFT) : '0;

  assign w_mem_x  = {{2{r_mem[MEM_WIDTH-1]}}, r_mem};
  assign w_leak_x = {{2{w_leak[MEM_WIDTH-1]}}, w_leak};
  assign w_cur_x  = {{(W2-8){current[7]}}, current};
  assign w_sum    = w_mem_x - w_leak_x + w_cur_x;

  // Clamp the widened sum back into the membrane range.
  always_comb begin
    w_vnext = w_sum[MEM_WIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_vnext = SAT_MAX[MEM_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_vnext = SAT_MIN[MEM_WIDTH-1:0];
    end
  end

  assign w_vcmp = {{(32-MEM_WIDTH){w_vnext[MEM_WIDTH-1]}}, w_vnext};
  assign w_fire = (w_vcmp >= THR);

  // Neuron state machine: integrate/fire, refractory countdown, soft clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INTEGRATE;
      r_cnt   <= '0;
      r_mem   <= '0;
      r_spike <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_spike <= 1'b0;
      if (clear) begin
        r_state <= INTEGRATE;
        r_cnt   <= '0;
        r_mem   <= '0;
        r_count <= 8'd0;
      end else begin
        case (r_state)
          INTEGRATE: begin
            if (in_valid) begin
              if (w_fire) begin
                r_mem   <= '0;
                r_spike <= 1'b1;
                if (r_count != 8'hFF) begin
                  r_count <= r_count + 8'd1;
                end
                if (HAS_REFRAC) begin
                  r_state <= REFRAC;
                  r_cnt   <= REFRAC_LOAD;
                end
              end else begin
                r_mem <= w_vnext;
              end
            end
          end
          REFRAC: begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt <= CNT_ONE) begin
              r_state <= INTEGRATE;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= INTEGRATE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign in_ready    = (r_state == INTEGRATE);
  assign spike       = r_spike;
  assign membrane    = r_mem;
  assign spike_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_layer2.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_neuron_layer2
// Description : Self-checking bench for lif_neuron_layer2. Two instances
//               (refractory 2 and refractory 0) share all inputs and are
//               compared every cycle against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_layer2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic [7:0]        current;

  logic              rdy_a, spk_a, rdy_b, spk_b;
  logic signed [9:0] mem_a, mem_b;
  logic [7:0]        cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = refractory 2, index 1 = refractory 0
  int m_mem [2];
  int m_cnt [2];
  int m_ref [2];
  int m_spk [2];

  lif_neuron_layer2 #(.MEM_WIDTH(10), .THRESHOLD(64), .LEAK_SHIFT(3), .REFRAC_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .current(current),
    .in_ready(rdy_a), .spike(spk_a), .membrane(mem_a), .spike_count(cnt_a)
  );

  lif_neuron_layer2 #(.MEM_WIDTH(10), .THRESHOLD(64), .LEAK_SHIFT(3), .REFRAC_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .current(current),
    .in_ready(rdy_b), .spike(spk_b), .membrane(mem_b), .spike_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div8(input int x);
    if (x >= 0) return x / 8;
    return -((-x + 7) / 8);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mem[i] = 0; m_cnt[i] = 0; m_ref[i] = 0; m_spk[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int rc, input logic c, input logic v, input logic [7:0] cur);
    int leak;
    int nv;
    m_spk[i] = 0;
    if (c) begin
      m_mem[i] = 0; m_cnt[i] = 0; m_ref[i] = 0;
    end else if (m_ref[i] > 0) begin
      m_ref[i] = m_ref[i] - 1;
    end else if (v) begin
`ifdef LIF_NEURON_LEAK_EN
      leak = floor_div8(m_mem[i]);
`else
      leak = 0;
`endif
      nv = m_mem[i] - leak + int'($signed(cur));
      if (nv > 511)  nv = 511;
      if (nv < -512) nv = -512;
      if (nv >= 64) begin
        m_mem[i] = 0;
        m_spk[i] = 1;
        if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        m_ref[i] = rc;
      end else begin
        m_mem[i] = nv;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " A mem"},   mem_a,  m_mem[0]);
    check({tag, " A spike"}, spk_a,  m_spk[0]);
    check({tag, " A count"}, cnt_a,  m_cnt[0]);
    check({tag, " A ready"}, rdy_a,  (m_ref[0] == 0) ? 1 : 0);
    check({tag, " B mem"},   mem_b,  m_mem[1]);
    check({tag, " B spike"}, spk_b,  m_spk[1]);
    check({tag, " B count"}, cnt_b,  m_cnt[1]);
    check({tag, " B ready"}, rdy_b,  (m_ref[1] == 0) ? 1 : 0);
  endtask

  task automatic step(input string tag, input logic c, input logic v, input logic [7:0] cur);
    clear = c; in_valid = v; current = cur;
    @(posedge clk);
    #1;
    model_step(0, 2, c, v, cur);
    model_step(1, 0, c, v, cur);
    check_all(tag);
  endtask

  initial begin
    int lit_int [4];
    int lit_sat [5];
    lit_int = '{20, 40, 60, 0};
    lit_sat = '{-128, -256, -384, -512, -512};

    // Reset state
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; current = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Pure integration: 20 x4 -> 20, 40, 60, spike
    for (int k = 0; k < 4; k++) begin
      step("integ", 1'b0, 1'b1, 8'd20);
`ifndef LIF_NEURON_LEAK_EN
      check("integ lit mem", mem_a, lit_int[k]);
`endif
    end
`ifndef LIF_NEURON_LEAK_EN
    check("integ lit spike", spk_a, 1);
    check("integ lit count", cnt_a, 1);
`endif

    // Refractory: 100 held; A discards 2 cycles, accepts the 3rd
    step("refrac1", 1'b0, 1'b1, 8'd100);
    check("refrac1 lit A mem", mem_a, 0);
    check("refrac1 lit A ready", rdy_a, 0);
    step("refrac2", 1'b0, 1'b1, 8'd100);
    check("refrac2 lit A spike", spk_a, 0);
    check("refrac2 lit A ready", rdy_a, 1);
    step("refrac3", 1'b0, 1'b1, 8'd100);
    check("refrac3 lit A spike", spk_a, 1);

    // Let A leave refractory, then negative saturation
    step("idle", 1'b0, 1'b0, 8'd0);
    step("idle", 1'b0, 1'b0, 8'd0);
    step("clr", 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      step("negsat", 1'b0, 1'b1, 8'h80);
`ifndef LIF_NEURON_LEAK_EN
      check("negsat lit mem", mem_a, lit_sat[k]);
`endif
    end

    // Leak: 40, then 0 -> 35, then -8 -> 23
    step("clr", 1'b1, 1'b0, 8'd0);
    step("leak40", 1'b0, 1'b1, 8'd40);
    step("leak0", 1'b0, 1'b1, 8'd0);
`ifdef LIF_NEURON_LEAK_EN
    check("leak lit 35", mem_a, 35);
`endif
    step("leakm8", 1'b0, 1'b1, 8'hF8);
`ifdef LIF_NEURON_LEAK_EN
    check("leak lit 23", mem_a, 23);
`endif

    // Idle cycles hold membrane
    step("hold", 1'b0, 1'b0, 8'd50);
    step("hold", 1'b0, 1'b0, 8'd50);

    // Asynchronous reset mid-refractory
    step("prespike", 1'b0, 1'b1, 8'd100);
    check("prespike lit A ready", rdy_a, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async rst");
    check("async rst lit A ready", rdy_a, 1);
    #2 rst_n = 1'b1;
    step("post rst", 1'b0, 1'b1, 8'd30);
    check("post rst lit mem", mem_a, 30);

    // Clear beats a firing input
    step("spk", 1'b0, 1'b1, 8'd100);
    step("idle", 1'b0, 1'b0, 8'd0);
    step("idle", 1'b0, 1'b0, 8'd0);
    step("clr+valid", 1'b1, 1'b1, 8'd100);
    check("clr lit spike", spk_b, 0);
    check("clr lit mem", mem_b, 0);
    check("clr lit count", cnt_b, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    // Count saturation: 300 firing inputs with no refractory period
    step("clr", 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 300; k++) begin
      step("sat", 1'b0, 1'b1, 8'd127);
    end
    check("sat lit B count", cnt_b, 255);
    check("sat lit A count", cnt_a, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lif_neuron_layer2.md
LIF_NEURON_LAYER2 -- requirements
Module: lif_neuron_layer2

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 10: signed membrane-potential width in bits.
REQ-002 SHALL have parameter THRESHOLD, default 64: signed firing threshold, compared with >=.
REQ-003 SHALL have parameter LEAK_SHIFT, default 3: leak equals membrane arithmetic-shifted right by this amount.
REQ-004 SHALL have parameter REFRAC_CYCLES, default 2: refractory length in clocks; 0 means no refractory period.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port clear, input, 1 bit: synchronous soft clear of membrane, state and counter.
REQ-008 SHALL have port in_valid, input, 1 bit: current is valid this cycle.
REQ-009 SHALL have port current, input, 8 bits: signed weighted sum plus bias from the upstream layer-2 MAC/bias stage.
REQ-010 SHALL have port in_ready, output, 1 bit: high only in state INTEGRATE.
REQ-011 SHALL have port spike, output, 1 bit: registered one-cycle fire pulse.
REQ-012 SHALL have port membrane, output, MEM_WIDTH bits: signed registered membrane potential.
REQ-013 SHALL have port spike_count, output, 8 bits: unsigned saturating count of spikes since reset or clear.

Function
REQ-014 SHALL implement the FSM states INTEGRATE and REFRAC.
REQ-015 SHALL, in INTEGRATE with in_valid=1, compute v_next = sat(membrane - leak + sign-extended current).
- Saturation limits: -2^(MEM_WIDTH-1) and 2^(MEM_WIDTH-1)-1.
- Intermediate width: MEM_WIDTH+2 bits.
REQ-016 SHALL hold membrane unchanged in INTEGRATE when in_valid=0, with no leak on idle cycles.
REQ-017 SHALL, if v_next >= THRESHOLD, on the same edge:
- set membrane to 0;
- assert spike for exactly one cycle;
- increment spike_count;
- enter REFRAC with counter=REFRAC_CYCLES, or stay in INTEGRATE if REFRAC_CYCLES=0.
REQ-018 SHALL, if v_next < THRESHOLD, load membrane with v_next and keep spike=0.
REQ-019 SHALL, in REFRAC, decrement the counter every clock and return to INTEGRATE on the edge where the counter reaches 0.
REQ-020 SHALL discard in_valid inputs received while in REFRAC (in_ready=0), with no membrane change.
REQ-021 SHALL have latency of 1 clock from an accepted in_valid to the updated membrane and spike.
REQ-022 SHALL saturate spike_count at 255 with no wrap.
REQ-023 SHALL give clear priority over in_valid: membrane=0, spike=0, spike_count=0, state=INTEGRATE, counter=0.
REQ-024 SHALL not produce a spike or update the count on a clear cycle.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: membrane=0, spike=0, spike_count=0, state=INTEGRATE, refractory counter=0, in_ready=1.
REQ-026 SHALL allow reset at any point, including mid-REFRAC, to abandon the refractory period; the first accepted input after release integrates from 0.

Configuration
REQ-027 SHALL compile leak in only when macro LIF_NEURON_LEAK_EN is defined:
- defined: leak = membrane >>> LEAK_SHIFT;
- undefined: leak = 0 (pure integrate-and-fire), and LEAK_SHIFT is unused.

Verification
REQ-028 SHALL cover pure integration (LEAK_EN undefined, THRESHOLD=64): current=20 for 4 valid cycles -> membrane 20, 40, 60, then spike=1, membrane=0, spike_count=1.
REQ-029 SHALL cover leak (LIF_NEURON_LEAK_EN defined, LEAK_SHIFT=3): membrane=40, current=0 valid -> membrane=35; current=-8 from 35 -> 35-4-8=23.
REQ-030 SHALL cover refractory behaviour (REFRAC_CYCLES=2): after a spike, in_valid current=100 held for 2 cycles -> in_ready=0, membrane stays 0; on the 3rd cycle the input is accepted -> spike.
REQ-031 SHALL cover negative saturation (MEM_WIDTH=10): current=-128 for 5 valid cycles -> membrane -128, -256, -384, -512, -512.
REQ-032 SHALL cover reset and clear:
- rst_n pulsed low mid-REFRAC -> membrane=0, spike_count=0, in_ready=1 immediately.
- clear together with in_valid current=100 -> no spike, membrane=0.
REQ-033 SHALL cover count saturation: 300 forced spikes (current=127 each accepted cycle, REFRAC_CYCLES=0) -> spike_count=255.
